wb_master_if: RTL and testbench

Wishbone initiator for the SPI-to-Wishbone bridge. It converts single commands from the SPI command decoder into classic Wishbone single read/write cycles toward the register/buffer slave, then returns the read data or a timeout error on a response handshake. It supports one outstanding transaction at a time, and every cycle is bounded by a programmable ACK timeout.

---
 rtl/wb_master_if.sv | 111 +++++++++++
 tb/tb_wb_master_if.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_master_if.sv
// wb_master_if
// Wishbone initiator for the SPI-to-Wishbone bridge. It takes one command at
// a time from the SPI command decoder and runs a classic single read or
// write cycle. It then returns the read data, or a timeout error, on a
// valid/ready response channel.
//
// Parameters
//   TIMEOUT  maximum number of STB cycles to wait for ACK (>= 2)
//   AW, DW   address / data width
// Ports
//   WB_CLK_I, WB_RST_N_I           clock, async active-low reset
//   CMD_VALID/READY/WE/ADDR/DATA   command channel (READY decoded from state)
//   RSP_VALID/READY/DATA/ERR       response channel (registered)
//   WB_CYC_O/STB_O/WE_O/ADR_O/DAT_O, WB_DAT_I, WB_ACK_I  Wishbone initiator
module wb_master_if #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 8,
  parameter int DW      = 32
) (
  input  logic          WB_CLK_I,
  input  logic          WB_RST_N_I,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WE,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [DW-1:0] CMD_DATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_DATA,
  output logic          RSP_ERR,
  output logic          WB_CYC_O,
  output logic          WB_STB_O,
  output logic          WB_WE_O,
  output logic [AW-1:0] WB_ADR_O,
  output logic [DW-1:0] WB_DAT_O,
  input  logic [DW-1:0] WB_DAT_I,
  input  logic          WB_ACK_I
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value during the TIMEOUT-th STB cycle (it counts from 0).
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign CMD_READY = (state == IDLE);

  always_ff @(posedge WB_CLK_I or negedge WB_RST_N_I) begin
    if (!WB_RST_N_I) begin
      state     <= IDLE;
      cnt       <= '0;
      WB_CYC_O  <= 1'b0;
      WB_STB_O  <= 1'b0;
      WB_WE_O   <= 1'b0;
      WB_ADR_O  <= '0;
      WB_DAT_O  <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CMD_VALID) begin
            WB_WE_O  <= CMD_WE;
            WB_ADR_O <= CMD_ADDR;
            WB_DAT_O <= CMD_DATA;
            WB_CYC_O <= 1'b1;
            WB_STB_O <= 1'b1;
            cnt      <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // ACK is checked first so that an ACK in the last allowed cycle
          // still completes normally instead of aborting.
          if (WB_ACK_I) begin
            WB_CYC_O  <= 1'b0;
            WB_STB_O  <= 1'b0;
            WB_WE_O   <= 1'b0;
            RSP_DATA  <= WB_WE_O ? '0 : WB_DAT_I;
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else if (cnt == LAST) begin
            WB_CYC_O  <= 1'b0;
            WB_STB_O  <= 1'b0;
            WB_WE_O   <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b1;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          // RSP_DATA is left as is; it means nothing once RSP_VALID is low.
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_if.sv
module tb_wb_master_if;

  localparam int TO = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic          rsp_valid, rsp_err;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic          ack = 1'b0;

  int nchk = 0;
  int nfail = 0;

  wb_master_if #(.TIMEOUT(TO), .AW(AW), .DW(DW)) dut (
    .WB_CLK_I(clk), .WB_RST_N_I(rst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WE(cmd_we),
    .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .RSP_ERR(rsp_err),
    .WB_CYC_O(cyc), .WB_STB_O(stb), .WB_WE_O(we), .WB_ADR_O(adr),
    .WB_DAT_O(dat_o), .WB_DAT_I(dat_i), .WB_ACK_I(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: the slave acks in STB cycle ack_at
  // (0 or > TO means it would never ack in time).
  function automatic void ref_model(input logic w, input int ack_at, input logic [31:0] rd,
                                    output logic err, output logic [31:0] d, output int nstb);
    if (ack_at >= 1 && ack_at <= TO) begin
      err = 1'b0; d = w ? 32'h0 : rd; nstb = ack_at;
    end else begin
      err = 1'b1; d = 32'h0; nstb = TO;
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle. Runs one command,
  // plays the slave, applies bp cycles of backpressure, then drains.
  task automatic run_txn(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ack_at, input logic [DW-1:0] rd,
                         input int bp, input logic exp_err, input logic [DW-1:0] exp_d,
                         input int exp_stb);
    int  k = 0;
    bit  done = 0;
    chk({tag, ".ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1;
    // Scramble the command inputs to show the block registered them.
    cmd_valid = 1'b0; cmd_we = ~w; cmd_addr = ~a; cmd_data = $urandom;
    while (!done && k < TO + 2) begin
      k++;
      chk({tag, ".cyc"}, 32'(cyc), 32'd1);
      chk({tag, ".stb"}, 32'(stb), 32'd1);
      chk({tag, ".we"}, 32'(we), 32'(w));
      chk({tag, ".adr"}, 32'(adr), 32'(a));
      chk({tag, ".dat_o"}, dat_o, d);
      chk({tag, ".ready_req"}, 32'(cmd_ready), 32'd0);
      ack   = (k == ack_at);
      dat_i = ack ? rd : $urandom;
      @(posedge clk); #1;
      ack = 1'b0;
      if (rsp_valid) done = 1;
    end
    chk({tag, ".rsp_seen"}, 32'(done), 32'd1);
    chk({tag, ".stb_cycles"}, k, exp_stb);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ".rsp_data"}, rsp_data, exp_d);
    chk({tag, ".cyc_off"}, 32'({cyc, stb, we}), 32'd0);
    for (int i = 0; i < bp; i++) begin
      ack = 1'($urandom);   // stray ACK while in RESP must be ignored
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".bp_data"}, rsp_data, exp_d);
      chk({tag, ".bp_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, ".bp_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, ".bp_cyc"}, 32'({cyc, stb}), 32'd0);
    end
    ack = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".drain_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".drain_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".drain_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ack_at;
    logic [DW-1:0] rd;
    int            bp;
    logic          exp_err;
    logic [DW-1:0] exp_d;
    int            exp_stb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic          e;
    logic [31:0]   ed;
    int            es;
    logic          rw;
    int            ra;
    logic [31:0]   rr;

    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 2, 32'hFFFF0000, 0, 1'b0, 32'h0, 2};
    vecs[1] = '{1'b0, 8'h04, 32'h0, 1, 32'h12345678, 0, 1'b0, 32'h12345678, 1};
    vecs[2] = '{1'b0, 8'h20, 32'h0, 0, 32'h11111111, 1, 1'b1, 32'h0, TO};
    vecs[3] = '{1'b0, 8'h30, 32'h0, TO, 32'hA5A5A5A5, 0, 1'b0, 32'hA5A5A5A5, TO};
    vecs[4] = '{1'b0, 8'h44, 32'h0, 3, 32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 3};
    vecs[5] = '{1'b1, 8'hFF, 32'h0BADC0DE, 0, 32'h0, 2, 1'b1, 32'h0, TO};

    // Reset state, with a command offered during reset that must be dropped.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h55; cmd_data = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cyc_stb_we", 32'({cyc, stb, we}), 32'd0);
    chk("rst.adr", 32'(adr), 32'd0);
    chk("rst.dat_o", dat_o, 32'd0);
    chk("rst.rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Spurious ACK while idle.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("idle_ack.cyc", 32'({cyc, stb}), 32'd0);
    chk("idle_ack.rsp", 32'(rsp_valid), 32'd0);
    chk("idle_ack.ready", 32'(cmd_ready), 32'd1);

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].ack_at,
              vecs[i].rd, vecs[i].bp, vecs[i].exp_err, vecs[i].exp_d, vecs[i].exp_stb);

    // Reset in the 2nd STB cycle, off-edge.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h08;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mrst.stb1", 32'(stb), 32'd1);
    @(posedge clk); #3;
    chk("mrst.stb2", 32'(stb), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst.cyc_stb", 32'({cyc, stb}), 32'd0);
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst.ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst.after_cyc", 32'({cyc, stb}), 32'd0);
    chk("mrst.after_rsp", 32'(rsp_valid), 32'd0);
    run_txn("mrst.read", 1'b0, 8'h0C, 32'h0, 1, 32'h600DF00D, 0, 1'b0, 32'h600DF00D, 1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom);
      ra = int'($urandom_range(0, TO + 2));
      rr = $urandom;
      ref_model(rw, ra, rr, e, ed, es);
      run_txn($sformatf("rnd%0d", n), rw, 8'($urandom), $urandom, ra, rr,
              int'($urandom_range(0, 3)), e, ed, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
